// File: rtl/car_pkg.sv
// rtl/car_pkg.sv - shared state encoding and default widths for the carrier Doppler sweep
package car_pkg;

  localparam int CAR_ACC_WIDTH   = 32;
  localparam int CAR_BIN_WIDTH   = 8;
  localparam int CAR_DWELL_WIDTH = 16;

  typedef enum logic [2:0] {
    CAR_IDLE     = 3'd0,
    CAR_SETTLE   = 3'd1,
    CAR_DWELL    = 3'd2,
    CAR_WAIT_DET = 3'd3,
    CAR_LOCK     = 3'd4
  } car_state_e;

endpackage

// File: rtl/car_dwell_cnt.sv
// rtl/car_dwell_cnt.sv - loadable dwell counter with terminal-count flag
module car_dwell_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] len_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q;

  // Count enabled clocks; a load restarts the dwell from zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  // len_i is at least 1, so the last counted clock is len_i-1.
  assign tc_o = (cnt_q == len_i - WIDTH'(1));

endmodule

// File: rtl/car_dopp_sweep_ctrl.sv
// rtl/car_dopp_sweep_ctrl.sv - carrier NCO Doppler-bin sweep sequencer (CAR_SWEEP_WRAP_EN: continuous sweep)
module car_dopp_sweep_ctrl
  import car_pkg::*;
#(
  parameter int ACC_WIDTH   = CAR_ACC_WIDTH,
  parameter int BIN_WIDTH   = CAR_BIN_WIDTH,
  parameter int DWELL_WIDTH = CAR_DWELL_WIDTH
) (
  input  logic                   rx_clk,
  input  logic                   rx_rst_n,
  input  logic                   rx_start,
  input  logic                   rx_abort,
  input  logic [ACC_WIDTH-1:0]   rx_fcw_start,
  input  logic [ACC_WIDTH-1:0]   rx_fcw_step,
  input  logic [BIN_WIDTH-1:0]   rx_num_bins,
  input  logic [DWELL_WIDTH-1:0] rx_dwell_len,
  input  logic                   rx_det_valid,
  input  logic                   rx_det_hit,
  output logic [ACC_WIDTH-1:0]   tx_car_fcw,
  output logic                   tx_car_rst,
  output logic                   tx_dump,
  output logic [BIN_WIDTH-1:0]   tx_bin_idx,
  output logic                   tx_busy,
  output logic                   tx_done,
  output logic                   tx_found,
  output logic [ACC_WIDTH-1:0]   tx_hit_fcw
);

  car_state_e             state_q, state_d;
  logic [ACC_WIDTH-1:0]   fcw_q, fcw_d;
  logic [ACC_WIDTH-1:0]   step_q, step_d;
  logic [BIN_WIDTH-1:0]   nbins_q, nbins_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
  logic [BIN_WIDTH-1:0]   bin_q, bin_d;
  logic [ACC_WIDTH-1:0]   hit_fcw_q, hit_fcw_d;
  logic                   car_rst_q, car_rst_d;
  logic                   dump_q, dump_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   found_q, found_d;
  logic                   cnt_load, cnt_en, cnt_tc;
`ifdef CAR_SWEEP_WRAP_EN
  logic [ACC_WIDTH-1:0]   fcw_start_q, fcw_start_d;
`endif

  car_dwell_cnt #(
    .WIDTH (DWELL_WIDTH)
  ) u_dwell_cnt (
    .clk_i  (rx_clk),
    .rst_ni (rx_rst_n),
    .load_i (cnt_load),
    .en_i   (cnt_en),
    .len_i  (dwell_q),
    .tc_o   (cnt_tc)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d   = state_q;
    fcw_d     = fcw_q;
    step_d    = step_q;
    nbins_d   = nbins_q;
    dwell_d   = dwell_q;
    bin_d     = bin_q;
    hit_fcw_d = hit_fcw_q;
    done_d    = 1'b0;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
`ifdef CAR_SWEEP_WRAP_EN
    fcw_start_d = fcw_start_q;
`endif

    if (rx_abort) begin
      state_d = CAR_IDLE;
    end else begin
      case (state_q)
        CAR_IDLE, CAR_LOCK: begin
          if (rx_start) begin
            // Zero bin count / dwell are stored as 1 so the rest of the FSM never special-cases them.
            step_d  = rx_fcw_step;
            nbins_d = (rx_num_bins == '0) ? BIN_WIDTH'(1) : rx_num_bins;
            dwell_d = (rx_dwell_len == '0) ? DWELL_WIDTH'(1) : rx_dwell_len;
            fcw_d   = rx_fcw_start;
            bin_d   = '0;
`ifdef CAR_SWEEP_WRAP_EN
            fcw_start_d = rx_fcw_start;
`endif
            state_d = CAR_SETTLE;
          end
        end
        CAR_SETTLE: begin
          cnt_load = 1'b1;
          state_d  = CAR_DWELL;
        end
        CAR_DWELL: begin
          cnt_en = 1'b1;
          if (cnt_tc) begin
            state_d = CAR_WAIT_DET;
          end
        end
        CAR_WAIT_DET: begin
          if (rx_det_valid) begin
            if (rx_det_hit) begin
              hit_fcw_d = fcw_q;
              state_d   = CAR_LOCK;
            end else if (bin_q == nbins_q - BIN_WIDTH'(1)) begin
              done_d = 1'b1;
`ifdef CAR_SWEEP_WRAP_EN
              bin_d   = '0;
              fcw_d   = fcw_start_q;
              state_d = CAR_SETTLE;
`else
              state_d = CAR_IDLE;
`endif
            end else begin
              bin_d   = bin_q + BIN_WIDTH'(1);
              fcw_d   = fcw_q + step_q;
              state_d = CAR_SETTLE;
            end
          end
        end
        default: state_d = CAR_IDLE;
      endcase
    end

    // Outputs are decoded from the next state so they are registered yet aligned with the state.
    car_rst_d = (state_d == CAR_IDLE) || (state_d == CAR_SETTLE);
    busy_d    = (state_d == CAR_SETTLE) || (state_d == CAR_DWELL) || (state_d == CAR_WAIT_DET);
    found_d   = (state_d == CAR_LOCK);
    dump_d    = (state_q == CAR_DWELL) && (state_d == CAR_WAIT_DET);
  end

  // State and output registers.
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      state_q   <= CAR_IDLE;
      fcw_q     <= '0;
      step_q    <= '0;
      nbins_q   <= '0;
      dwell_q   <= '0;
      bin_q     <= '0;
      hit_fcw_q <= '0;
      car_rst_q <= 1'b1;
      dump_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      found_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      fcw_q     <= fcw_d;
      step_q    <= step_d;
      nbins_q   <= nbins_d;
      dwell_q   <= dwell_d;
      bin_q     <= bin_d;
      hit_fcw_q <= hit_fcw_d;
      car_rst_q <= car_rst_d;
      dump_q    <= dump_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      found_q   <= found_d;
    end
  end

`ifdef CAR_SWEEP_WRAP_EN
  // Latched bin-0 FCW, reloaded at the start of every pass.
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      fcw_start_q <= '0;
    end else begin
      fcw_start_q <= fcw_start_d;
    end
  end
`endif

  assign tx_car_fcw = fcw_q;
  assign tx_car_rst = car_rst_q;
  assign tx_dump    = dump_q;
  assign tx_bin_idx = bin_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;
  assign tx_found   = found_q;
  assign tx_hit_fcw = hit_fcw_q;

endmodule

// File: tb/tb_car_dopp_sweep_ctrl.sv
// tb/tb_car_dopp_sweep_ctrl.sv - self-checking bench for car_dopp_sweep_ctrl
module tb_car_dopp_sweep_ctrl;

  logic        rx_clk = 1'b0;
  logic        rx_rst_n = 1'b0;
  logic        rx_start = 1'b0;
  logic        rx_abort = 1'b0;
  logic [31:0] rx_fcw_start = '0;
  logic [31:0] rx_fcw_step = '0;
  logic [7:0]  rx_num_bins = '0;
  logic [15:0] rx_dwell_len = '0;
  logic        rx_det_valid = 1'b0;
  logic        rx_det_hit = 1'b0;
  logic [31:0] tx_car_fcw;
  logic        tx_car_rst;
  logic        tx_dump;
  logic [7:0]  tx_bin_idx;
  logic        tx_busy;
  logic        tx_done;
  logic        tx_found;
  logic [31:0] tx_hit_fcw;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int DWELL_BOUND = 100;

  car_dopp_sweep_ctrl dut (
    .rx_clk       (rx_clk),
    .rx_rst_n     (rx_rst_n),
    .rx_start     (rx_start),
    .rx_abort     (rx_abort),
    .rx_fcw_start (rx_fcw_start),
    .rx_fcw_step  (rx_fcw_step),
    .rx_num_bins  (rx_num_bins),
    .rx_dwell_len (rx_dwell_len),
    .rx_det_valid (rx_det_valid),
    .rx_det_hit   (rx_det_hit),
    .tx_car_fcw   (tx_car_fcw),
    .tx_car_rst   (tx_car_rst),
    .tx_dump      (tx_dump),
    .tx_bin_idx   (tx_bin_idx),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done),
    .tx_found     (tx_found),
    .tx_hit_fcw   (tx_hit_fcw)
  );

  always #5 rx_clk = ~rx_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge rx_clk);
    #1;
  endtask

  task automatic check_reset_vals(input string pfx);
    check_eq({pfx, "_fcw"},     tx_car_fcw, 32'h0);
    check_eq({pfx, "_car_rst"}, 32'(tx_car_rst), 32'h1);
    check_eq({pfx, "_dump"},    32'(tx_dump), 32'h0);
    check_eq({pfx, "_bin"},     32'(tx_bin_idx), 32'h0);
    check_eq({pfx, "_busy"},    32'(tx_busy), 32'h0);
    check_eq({pfx, "_done"},    32'(tx_done), 32'h0);
    check_eq({pfx, "_found"},   32'(tx_found), 32'h0);
    check_eq({pfx, "_hit_fcw"}, tx_hit_fcw, 32'h0);
  endtask

  // Run one sweep; hit_v is the 0-based verdict index that reports a hit (-1: never).
  // Expected FCW of bin k is computed directly as start + k*step modulo 2^32.
  task automatic run_sweep(input logic [31:0] fs, input logic [31:0] fst, input logic [7:0] nb,
                           input logic [15:0] dl, input int hit_v, input int max_v);
    int          nb_eff;
    int          dl_eff;
    int          k;
    int          cnt;
    int          w;
    bit          hit;
    logic [31:0] e;
    nb_eff = (nb == 0) ? 1 : int'(nb);
    dl_eff = (dl == 0) ? 1 : int'(dl);
    k = 0;
    rx_fcw_start = fs;
    rx_fcw_step  = fst;
    rx_num_bins  = nb;
    rx_dwell_len = dl;
    rx_start     = 1'b1;
    step_clk();
    rx_start = 1'b0;
    for (int v = 0; v < max_v; v++) begin
      e = fs + fst * k;
      check_eq("settle_car_rst", 32'(tx_car_rst), 32'h1);
      check_eq("settle_busy", 32'(tx_busy), 32'h1);
      check_eq("settle_fcw", tx_car_fcw, e);
      check_eq("settle_bin", 32'(tx_bin_idx), k);
      // Count DWELL clocks while throwing ignored stimulus and config churn at the DUT.
      cnt = 0;
      step_clk();
      while (tx_dump !== 1'b1 && cnt < DWELL_BOUND) begin
        check_eq("dwell_car_rst", 32'(tx_car_rst), 32'h0);
        cnt++;
        rx_det_valid = 1'($urandom);
        rx_det_hit   = 1'b1;
        rx_start     = 1'($urandom);
        rx_fcw_start = $urandom;
        rx_fcw_step  = $urandom;
        rx_num_bins  = 8'($urandom);
        rx_dwell_len = 16'($urandom);
        step_clk();
      end
      rx_det_valid = 1'b0;
      check_eq("dwell_cycles", cnt, dl_eff);
      check_eq("dump_car_rst", 32'(tx_car_rst), 32'h0);
      check_eq("dump_busy", 32'(tx_busy), 32'h1);
      w = int'($urandom_range(0, 2));
      for (int i = 0; i < w; i++) begin
        step_clk();
        check_eq("dump_one_cycle", 32'(tx_dump), 32'h0);
        check_eq("wait_busy", 32'(tx_busy), 32'h1);
      end
      hit = (v == hit_v);
      rx_det_valid = 1'b1;
      rx_det_hit   = hit;
      step_clk();
      rx_det_valid = 1'b0;
      rx_det_hit   = 1'b0;
      rx_start     = 1'b0;
      check_eq("post_dump", 32'(tx_dump), 32'h0);
      if (hit) begin
        check_eq("hit_found", 32'(tx_found), 32'h1);
        check_eq("hit_fcw", tx_hit_fcw, e);
        check_eq("hit_bin", 32'(tx_bin_idx), k);
        check_eq("hit_car_fcw", tx_car_fcw, e);
        check_eq("hit_busy", 32'(tx_busy), 32'h0);
        check_eq("hit_car_rst", 32'(tx_car_rst), 32'h0);
        check_eq("hit_done", 32'(tx_done), 32'h0);
        return;
      end else if (k == nb_eff - 1) begin
        check_eq("pass_done", 32'(tx_done), 32'h1);
`ifdef CAR_SWEEP_WRAP_EN
        check_eq("wrap_busy", 32'(tx_busy), 32'h1);
        k = 0;
`else
        check_eq("end_busy", 32'(tx_busy), 32'h0);
        check_eq("end_found", 32'(tx_found), 32'h0);
        check_eq("end_fcw", tx_car_fcw, e);
        check_eq("end_car_rst", 32'(tx_car_rst), 32'h1);
        step_clk();
        check_eq("done_one_cycle", 32'(tx_done), 32'h0);
        return;
`endif
      end else begin
        check_eq("miss_done", 32'(tx_done), 32'h0);
        k++;
      end
    end
    // Verdict budget used up (continuous sweep): leave via abort.
    rx_abort = 1'b1;
    step_clk();
    rx_abort = 1'b0;
    check_eq("budget_abort_busy", 32'(tx_busy), 32'h0);
    check_eq("budget_abort_done", 32'(tx_done), 32'h0);
  endtask

  initial begin
    int cnt;
    int nb_r;
    int hv;
    int mv;
    repeat (3) step_clk();
    check_reset_vals("rst");
    rx_rst_n = 1'b1;
    step_clk();
    check_eq("idle_car_rst", 32'(tx_car_rst), 32'h1);

    // Hit on the third verdict.
    run_sweep(32'h1000, 32'h100, 8'd5, 16'd4, 2, 1000);
    check_eq("tp_hit_fcw", tx_hit_fcw, 32'h1200);
    check_eq("tp_hit_bin", 32'(tx_bin_idx), 32'd2);

    // Abort from LOCK keeps FCW, bin and hit FCW.
    rx_abort = 1'b1;
    step_clk();
    rx_abort = 1'b0;
    check_eq("lock_abort_found", 32'(tx_found), 32'h0);
    check_eq("lock_abort_hit_fcw", tx_hit_fcw, 32'h1200);
    check_eq("lock_abort_fcw", tx_car_fcw, 32'h1200);
    check_eq("lock_abort_bin", 32'(tx_bin_idx), 32'd2);
    check_eq("lock_abort_car_rst", 32'(tx_car_rst), 32'h1);

    // Three misses end the sweep; zero bins/dwell act as one.
    run_sweep(32'h2000, 32'h40, 8'd3, 16'd2, -1, 7);
    run_sweep(32'h3000, 32'h10, 8'd0, 16'd0, -1, 3);

    // FCW wraps silently modulo 2^32.
    run_sweep(32'hFFFF_FF80, 32'h100, 8'd3, 16'd1, 1, 1000);
    check_eq("tp_wrap_fcw", tx_hit_fcw, 32'h0000_0080);

    // Restart from LOCK, then continuous/no-hit two-bin sweep.
    run_sweep(32'h5000, 32'hFFFF_FF00, 8'd4, 16'd3, 3, 1000);
    run_sweep(32'h7000, 32'h200, 8'd2, 16'd1, -1, 5);

    // Abort with simultaneous start in WAIT_DET.
    rx_fcw_start = 32'hABC0;
    rx_fcw_step  = 32'h10;
    rx_num_bins  = 8'd4;
    rx_dwell_len = 16'd3;
    rx_start     = 1'b1;
    step_clk();
    rx_start = 1'b0;
    cnt = 0;
    while (tx_dump !== 1'b1 && cnt < DWELL_BOUND) begin
      cnt++;
      step_clk();
    end
    check_eq("abort_reach_dump", 32'(tx_dump), 32'h1);
    rx_abort = 1'b1;
    rx_start = 1'b1;
    step_clk();
    rx_abort = 1'b0;
    rx_start = 1'b0;
    check_eq("abort_busy", 32'(tx_busy), 32'h0);
    check_eq("abort_done", 32'(tx_done), 32'h0);
    check_eq("abort_found", 32'(tx_found), 32'h0);
    check_eq("abort_car_rst", 32'(tx_car_rst), 32'h1);
    check_eq("abort_fcw", tx_car_fcw, 32'hABC0);
    check_eq("abort_bin", 32'(tx_bin_idx), 32'd0);
    rx_det_valid = 1'b1;
    rx_det_hit   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step_clk();
      check_eq("idle_ignore_found", 32'(tx_found), 32'h0);
      check_eq("idle_ignore_busy", 32'(tx_busy), 32'h0);
      check_eq("idle_ignore_done", 32'(tx_done), 32'h0);
    end
    rx_det_valid = 1'b0;
    rx_det_hit   = 1'b0;

    // Randomized sweeps.
    for (int t = 0; t < 14; t++) begin
      nb_r = int'($urandom_range(0, 6));
      hv   = int'($urandom_range(0, 8)) - 1;
      mv   = ((nb_r == 0) ? 1 : nb_r) * 2 + 1;
      run_sweep($urandom, $urandom, 8'(nb_r), 16'($urandom_range(0, 8)), hv, mv);
    end

    // Asynchronous reset in DWELL takes effect without a clock edge.
    rx_fcw_start = 32'h1234_5678;
    rx_fcw_step  = 32'h1;
    rx_num_bins  = 8'd2;
    rx_dwell_len = 16'd10;
    rx_start     = 1'b1;
    step_clk();
    rx_start = 1'b0;
    step_clk();
    step_clk();
    check_eq("pre_reset_busy", 32'(tx_busy), 32'h1);
    rx_rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    step_clk();
    rx_rst_n = 1'b1;
    step_clk();
    check_reset_vals("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/car_dopp_sweep_ctrl.md
Name: car_dopp_sweep_ctrl

Overview:
- Controller that sequences the carrier NCO during acquisition.
- Steps the NCO frequency control word through a programmed list of Doppler bins and holds each bin for a programmed dwell.
- Pulses a dump strobe to the correlator/integrator at the end of each dwell, then waits for the detector verdict.
- Locks on the first hit; otherwise finishes the sweep and reports done. Sits between the acquisition control registers and the carrier NCO's FCW and reset inputs.

Parameters:
- ACC_WIDTH, 32: FCW and phase-accumulator width; must match the carrier NCO.
- BIN_WIDTH, 8: width of the bin count and bin index.
- DWELL_WIDTH, 16: width of the dwell-length counter, in clocks.

Ports:
- rx_clk  in  1  system clock
- rx_rst_n  in  1  reset, asynchronous, active-low
- rx_start  in  1  one-cycle pulse; latches config and starts the sweep
- rx_abort  in  1  one-cycle pulse; returns to idle
- rx_fcw_start  in  ACC_WIDTH  FCW of bin 0
- rx_fcw_step  in  ACC_WIDTH  FCW increment per bin (two's complement permitted)
- rx_num_bins  in  BIN_WIDTH  number of bins; 0 is treated as 1
- rx_dwell_len  in  DWELL_WIDTH  clocks per dwell; 0 is treated as 1
- rx_det_valid  in  1  detector verdict strobe
- rx_det_hit  in  1  verdict, qualified by rx_det_valid
- tx_car_fcw  out  ACC_WIDTH  FCW to the NCO
- tx_car_rst  out  1  active-high synchronous reset to the NCO phase accumulator
- tx_dump  out  1  end-of-dwell pulse
- tx_bin_idx  out  BIN_WIDTH  current bin index
- tx_busy  out  1  high in SETTLE, DWELL, WAIT_DET
- tx_done  out  1  one-cycle pulse when the sweep ends without a hit
- tx_found  out  1  high while in LOCK
- tx_hit_fcw  out  ACC_WIDTH  FCW of the hit bin

Behaviour:
- Reset values: tx_car_fcw=0, tx_car_rst=1, tx_dump=0, tx_bin_idx=0, tx_busy=0, tx_done=0, tx_found=0, tx_hit_fcw=0. FSM in IDLE, all counters 0.
- FSM states: IDLE, SETTLE, DWELL, WAIT_DET, LOCK. All outputs are registered.
- IDLE:
  - tx_car_rst=1.
  - On rx_start: latch all rx_* config, load tx_car_fcw=rx_fcw_start, set bin_idx=0, go to SETTLE.
- SETTLE:
  - Lasts exactly 1 cycle with tx_car_rst=1, so the NCO restarts phase on the new FCW.
  - Next state DWELL; dwell counter cleared.
- DWELL:
  - tx_car_rst=0; counter increments each cycle.
  - After exactly max(dwell_len,1) cycles, go to WAIT_DET, with tx_dump=1 on the first WAIT_DET cycle only.
- WAIT_DET:
  - The NCO keeps running and the FCW is held.
  - rx_det_valid is sampled only in this state and ignored elsewhere.
  - valid & hit: tx_hit_fcw<=tx_car_fcw, go to LOCK.
  - valid & ~hit on the last bin (bin_idx==max(num_bins,1)-1): tx_done=1 for one cycle, go to IDLE.
  - valid & ~hit otherwise: bin_idx+1, tx_car_fcw<=tx_car_fcw+fcw_step mod 2^ACC_WIDTH (silent wrap), go to SETTLE.
  - No timeout; the state waits indefinitely.
- LOCK:
  - tx_found=1, tx_car_rst=0; FCW and bin_idx held.
  - rx_start restarts the sweep (via SETTLE); rx_abort goes to IDLE.
- Abort:
  - rx_abort in any state goes to IDLE on the next edge. No tx_done pulse.
  - tx_found clears; tx_car_fcw, tx_bin_idx and tx_hit_fcw retain their values.
  - rx_abort has priority over rx_start in the same cycle.
- rx_start while busy is ignored.
- Config is latched only on an accepted start; changes to the rx_* config inputs mid-sweep have no effect.
- Asynchronous reset mid-operation forces the reset values immediately.

Optional Feature:
- Macro: CAR_SWEEP_WRAP_EN.
- Defined: on a no-hit verdict in the last bin, the sweep does not end. bin_idx returns to 0, tx_car_fcw reloads the latched fcw_start, go to SETTLE, and tx_done pulses for one cycle as a pass marker while tx_busy stays high. The sweep ends only on a hit or an abort.
- Undefined: single pass as described under Behaviour.

Decomposition:
- Shared package car_pkg:
  - FSM state enum (3-bit encoding IDLE=0, SETTLE=1, DWELL=2, WAIT_DET=3, LOCK=4).
  - Default widths CAR_ACC_WIDTH=32, CAR_BIN_WIDTH=8, CAR_DWELL_WIDTH=16.
- One natural sub-module, car_dwell_cnt: a loadable dwell counter with a terminal-count output, reused by later tracking-loop blocks.

Test Plan:
- Hit in bin 2: start=0x1000, step=0x100, bins=5, dwell=4; hit on the 3rd verdict -> tx_hit_fcw=0x1200, tx_bin_idx=2, tx_found=1, tx_car_rst low from the DWELL entry onward. Also checks dwell=4 gives 4 DWELL cycles, then tx_dump.
- No hit, bins=3: three misses -> tx_done one-cycle pulse, state IDLE, tx_car_fcw=start+2*step, tx_found=0.
- Edge values: bins=0 and dwell=0 -> exactly one bin of one cycle, then tx_dump. A miss gives tx_done.
- FCW wrap: start=0xFFFFFF80, step=0x100 -> bin 1 FCW=0x00000080.
- Abort during WAIT_DET with rx_start in the same cycle -> IDLE, no tx_done, later rx_det_valid ignored. Async reset asserted in DWELL -> all reset values immediately.
- Wrap macro, bins=2, all misses -> tx_done pulses every 2 verdicts, tx_busy stays 1, bin 0 FCW reloads to start.
